// File: rtl/pipo_load_arbiter.sv
// Round-robin sequencer sharing one two-stage PIPO among N_REQ requesters.
// Tags each word through the PIPO and auto-flushes the last word after idling.
module pipo_load_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 4,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  input  logic                    i_flush,
  input  logic [DATA_W-1:0]       i_pipo_out,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_pipo_load,
  output logic [DATA_W-1:0]       o_pipo_data,
  output logic                    o_out_valid,
  output logic [$clog2(N_REQ)-1:0] o_out_id,
  output logic [DATA_W-1:0]       o_out_data,
  output logic                    o_busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (FLUSH_CYCLES == 0) ? '0 : CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_id;
  logic             win_hit;
  int               best;
  logic             s1_valid;
  logic [ID_W-1:0]  s1_id;
  logic [CNT_W-1:0] cnt;
  logic             grant_any;
  logic             timeout;
  logic             flush_issue;

  // Lowest rotated distance from the pointer wins.
  always_comb begin
    win_hit = 1'b0;
    win_id  = '0;
    best    = N_REQ;
    for (int k = 0; k < N_REQ; k++) begin
      if (i_req[k] && (((k + N_REQ - int'(ptr)) % N_REQ) < best)) begin
        win_hit = 1'b1;
        win_id  = ID_W'(k);
        best    = (k + N_REQ - int'(ptr)) % N_REQ;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (win_hit) state_nxt = HOLD;
      end
      HOLD: begin
        if (win_hit)          state_nxt = HOLD;
        else if (flush_issue) state_nxt = FLUSH;
      end
      FLUSH: begin
        state_nxt = win_hit ? HOLD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_any   = win_hit && !i_rst;
    timeout     = (FLUSH_CYCLES != 0) && (cnt == CNT_LAST);
    flush_issue = !i_rst && (state == HOLD) && !win_hit
                  && (i_flush || timeout);
    o_pipo_load = grant_any || flush_issue;
    o_pipo_data = '0;
    o_grant     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_any && (win_id == ID_W'(k))) begin
        o_grant[k]  = 1'b1;
        o_pipo_data = i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Tags advance exactly when the PIPO stages advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr         <= '0;
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      cnt         <= '0;
      o_out_valid <= 1'b0;
      o_out_id    <= '0;
    end else begin
      if (grant_any) begin
        ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
      end
      if (o_pipo_load) begin
        o_out_valid <= s1_valid;
        o_out_id    <= s1_id;
        s1_valid    <= grant_any;
        s1_id       <= win_id;
      end else begin
        o_out_valid <= 1'b0;
      end
      if (state == HOLD && !grant_any && !flush_issue) begin
        if (cnt != '1) cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  assign o_out_data = i_pipo_out;
  assign o_busy     = (state == HOLD);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Randomized bench for pipo_load_arbiter with a PIPO model and
// a word-order scoreboard checked at the PIPO output.
module tb_pipo_load_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int FC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst;
  logic [N-1:0]    i_req;
  logic [N*DW-1:0] i_data;
  logic            i_flush;
  logic [DW-1:0]   pipo_in;
  logic [DW-1:0]   pipo_out;
  logic [N-1:0]    o_grant;
  logic            o_pipo_load;
  logic [DW-1:0]   o_pipo_data;
  logic            o_out_valid;
  logic [1:0]      o_out_id;
  logic [DW-1:0]   o_out_data;
  logic            o_busy;

  pipo_load_arbiter #(
    .N_REQ(N), .DATA_W(DW), .FLUSH_CYCLES(FC)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_req(i_req),
    .i_data(i_data),
    .i_flush(i_flush),
    .i_pipo_out(pipo_out),
    .o_grant(o_grant),
    .o_pipo_load(o_pipo_load),
    .o_pipo_data(o_pipo_data),
    .o_out_valid(o_out_valid),
    .o_out_id(o_out_id),
    .o_out_data(o_out_data),
    .o_busy(o_busy)
  );

  // Two-stage PIPO: both stages advance on load.
  always @(posedge clk) begin
    if (i_rst) begin
      pipo_in  <= '0;
      pipo_out <= '0;
    end else if (o_pipo_load) begin
      pipo_out <= pipo_in;
      pipo_in  <= o_pipo_data;
    end
  end

  typedef struct {
    int            id;
    logic [DW-1:0] d;
  } word_t;

  word_t sb[$];
  int vec = 0;
  int bad = 0;

  int m_ptr  = 0;
  int m_full = 0;
  int m_idle = 0;
  int m_win  = -1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every tagged word must be the oldest outstanding grant.
  always @(negedge clk) begin : monitor
    word_t w;
    if (i_rst === 1'b0 && o_out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vec++;
        bad++;
        $display("FAIL out_valid: got id %0d with no word outstanding",
                 o_out_id);
      end else begin
        w = sb.pop_front();
        chk("out_id", 32'(o_out_id), 32'(w.id));
        chk("out_data", 32'(o_out_data), 32'(w.d));
      end
    end
  end

  task automatic step(input logic r, input logic [N-1:0] req,
                      input logic [N*DW-1:0] data, input logic fl);
    logic          ef;
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    word_t         w;
    i_rst   = r;
    i_req   = req;
    i_data  = data;
    i_flush = fl;
    @(negedge clk);
    if (r) begin
      chk("rst_grant", 32'(o_grant), 32'h0);
      chk("rst_load", 32'(o_pipo_load), 32'h0);
      m_ptr  = 0;
      m_full = 0;
      m_idle = 0;
      m_win  = -1;
      sb.delete();
    end else begin
      m_win = -1;
      for (int o = 0; o < N; o++) begin
        if (m_win < 0 && req[(m_ptr + o) % N]) m_win = (m_ptr + o) % N;
      end
      ef = (m_full != 0) && (m_win < 0)
           && (fl || (FC != 0 && m_idle >= FC - 1));
      eg = (m_win >= 0) ? N'(1) << m_win : '0;
      ed = (m_win >= 0) ? data[m_win*DW +: DW] : '0;
      chk("grant", 32'(o_grant), 32'(eg));
      chk("load", 32'(o_pipo_load), 32'((m_win >= 0) || ef));
      if ((m_win >= 0) || ef) chk("pipo_data", 32'(o_pipo_data), 32'(ed));
      chk("busy", 32'(o_busy), 32'(m_full));
      if (m_win >= 0) begin
        w.id = m_win;
        w.d  = ed;
        sb.push_back(w);
        m_ptr  = (m_win + 1) % N;
        m_full = 1;
        m_idle = 0;
      end else if (ef) begin
        m_full = 0;
        m_idle = 0;
      end else if (m_full != 0) begin
        m_idle++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0]    pend;
  logic [N*DW-1:0] pdata;
  logic            fl;
  logic            rr;
  int              rate;

  initial begin
    i_rst   = 1'b1;
    i_req   = '0;
    i_data  = '0;
    i_flush = 1'b0;
    @(posedge clk);
    #1;
    // Reset with all requests asserted.
    step(1'b1, 4'hF, 16'h4321, 1'b0);
    step(1'b1, 4'hF, 16'h4321, 1'b0);
    chk("rst_out_valid", 32'(o_out_valid), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    // Single word, auto-flushed after the idle timeout.
    step(1'b0, 4'b0100, 16'h0A00, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0, 16'h0, 1'b0);
    chk("idle_busy", 32'(o_busy), 32'h0);
    // Round robin with all requesting.
    for (int i = 0; i < 10; i++) step(1'b0, 4'hF, 16'h4321, 1'b0);
    // Pointer wrap cases.
    step(1'b0, 4'b0100, 16'h0500, 1'b0);
    step(1'b0, 4'b1001, 16'h7006, 1'b0);
    step(1'b0, 4'b1001, 16'h8009, 1'b0);
    step(1'b0, 4'b0001, 16'h000C, 1'b0);
    // Grant beats flush, then flush, then flush ignored.
    step(1'b0, 4'b0010, 16'h00D0, 1'b1);
    step(1'b0, 4'h0, 16'h0, 1'b1);
    step(1'b0, 4'h0, 16'h0, 1'b1);
    step(1'b0, 4'h0, 16'h0, 1'b1);
    chk("flush_idle_load", 32'(o_pipo_load), 32'h0);
    // Reset in the middle of a stream.
    for (int i = 0; i < 5; i++) step(1'b0, 4'hF, 16'hB7E2, 1'b0);
    step(1'b1, 4'hF, 16'hB7E2, 1'b0);
    chk("midrst_out_valid", 32'(o_out_valid), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'hF, 16'h1F3C, 1'b0);
    // Random traffic with held requests, flushes and resets.
    pend  = '0;
    pdata = '0;
    for (int c = 0; c < 800; c++) begin
      rate = (c < 400) ? 2 : 15;
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, rate) == 0) begin
          pend[k] = 1'b1;
          pdata[k*DW +: DW] = DW'($urandom);
        end
      end
      fl = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 99) == 0);
      step(rr, pend, pdata, fl);
      if (!rr && m_win >= 0) pend[m_win] = 1'b0;
    end
    // Drain via timeout and check nothing was lost.
    for (int i = 0; i < 20; i++) step(1'b0, 4'h0, 16'h0, 1'b0);
    chk("drain_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
